tftp_data_packer: RTL
=====================

Name: tftp_data_packer

Overview:
- Transmit-path stage directly downstream of the block-RAM reader. Turns one payload command (block number, byte count) into one TFTP DATA packet byte stream: opcode 0x0003, 16-bit block number, then payload bytes.
- Requests the payload from the reader and buffers it in an internal FIFO, because the reader has no per-byte backpressure.
- Streams the packet to the UDP/Ethernet framer under a valid/ready handshake.

Parameters:
- MAX_PAYLOAD, 512: maximum payload bytes per packet; also the FIFO depth.
- PTR_BITS, 9: FIFO address width; 2**PTR_BITS must equal MAX_PAYLOAD.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; the command is accepted on cmd_valid&&cmd_ready.
- cmd_block  in  16  TFTP block number placed in the header.
- cmd_length  in  16  payload byte count.
- mem_dr  in  1  reader is waiting for a read request.
- mem_read_request  out  1  one-cycle request to the reader.
- mem_dv  in  1  mem_data is valid this cycle.
- mem_data  in  8  payload byte from the reader.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts; a byte transfers on tx_valid&&tx_ready.
- tx_sof  out  1  first byte of the packet (opcode high byte).
- tx_eof  out  1  last byte of the packet.
- tx_len  out  16  total packet length (payload+4); stable from HDR until DONE.
- len_clamped  out  1  sticky; set when cmd_length > MAX_PAYLOAD; cleared on the next command accept.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in IDLE after reset. mem_read_request=0, tx_valid=0, tx_sof=0, tx_eof=0, tx_data=0, tx_len=0, len_clamped=0. FIFO emptied; state=IDLE.
- Command capture on accept:
  - blk_r <= cmd_block.
  - len_r <= min(cmd_length, MAX_PAYLOAD); len_clamped set if the value was clamped.
  - tx_len <= len_r+4, 16-bit, no overflow possible.
- States:
  - IDLE: cmd_ready=1. On accept -> REQ.
  - REQ: wait for mem_dr=1. In that cycle drive mem_read_request=1 for exactly one cycle. If len_r==0 -> HDR, else -> FILL.
  - FILL: each mem_dv cycle writes mem_data to the FIFO and increments fill_cnt. When fill_cnt reaches len_r -> HDR.
    - mem_dv after the count is reached is ignored; no FIFO write.
    - mem_dv in any state other than FILL is ignored.
  - HDR: emit 4 bytes, 0x00, 0x03, blk_r[15:8], blk_r[7:0]. The index advances only on a transfer. tx_sof=1 on byte 0. When len_r==0, tx_eof=1 on byte 3 and the next state is DONE; otherwise -> PAY.
  - PAY: tx_data comes from the FIFO read port. Registered read with one-cycle prefetch: first payload byte is valid the cycle after the last header byte transfers.
    - tx_valid is held while tx_ready=0; tx_data stays stable.
    - tx_eof=1 on byte len_r-1. After that transfer -> DONE.
  - DONE: one cycle; FIFO pointers cleared -> IDLE.
- Handshake rule: tx_valid never deasserts before a transfer, and tx_data never changes while tx_valid=1 and tx_ready=0.
- FIFO: single write port (FILL) and single read port (PAY), never active in the same cycle.
  - Write pointer wraps at MAX_PAYLOAD; count never exceeds MAX_PAYLOAD because length is clamped.
  - Read underflow is impossible: PAY starts only after FILL completes.
- Latency: first tx byte appears the cycle after entry to HDR. Minimum packet time: 1 (REQ) + len_r (FILL) + 4 + len_r transfers + 1.
- Reset mid-operation returns the block to IDLE within one cycle and discards the FIFO contents. No partial packet resumes.
- cmd_valid held during a busy packet is not accepted until IDLE.

Optional Feature:
- Macro TFTP_CSUM_EN.
- When defined:
  - Adds output csum 16 bits: running 16-bit one's-complement sum (end-around carry) of the packet bytes taken as big-endian 16-bit words.
  - The header counts as two words. An odd trailing payload byte is padded with 0x00 in the low byte.
  - Accumulated as bytes transfer on tx. Final value is valid in DONE and held until the next accept, where it clears to 0.
  - Reset value 0.
- When undefined: no csum port, no accumulator logic. All other behaviour is identical.

Test Plan:
- Command block=0x0001, len=4; reader supplies AA BB CC DD; tx_ready=1 -> tx = 00 03 00 01 AA BB CC DD; sof on byte 0, eof on byte 7, tx_len=8; csum=0x0003+0x0001+0xAABB+0xCCDD with end-around carry = 0x779D.
- len=0, block=0x1234 -> exactly one mem_read_request pulse; tx = 00 03 12 34 with eof on byte 3; tx_len=4; no FIFO writes.
- len=600 -> len_clamped=1; exactly 512 payload bytes emitted; eof on byte 515; extra mem_dv bytes ignored.
- len=512 with tx_ready toggling 1,0,0,1 pseudo-randomly -> byte sequence is unchanged and data stays stable while stalled; eof appears only on byte 515.
- mem_dr held low 20 cycles after accept -> request fires on the first mem_dr=1 cycle, not before; cmd_ready stays 0 throughout.
- Reset asserted mid-PAY after 100 payload bytes -> next cycle IDLE with all outputs at reset values. A new len=3 packet then emits only its own 7 bytes.

Source files
------------

// File: rtl/tftp_data_packer_if.sv
// Command, block-RAM reader and tx byte-stream signals of tftp_data_packer.
// The csum signal exists only when TFTP_CSUM_EN is defined.
interface tftp_data_packer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_block;
  logic [15:0] cmd_length;
  logic        mem_dr;
  logic        mem_read_request;
  logic        mem_dv;
  logic [7:0]  mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sof;
  logic        tx_eof;
  logic [15:0] tx_len;
  logic        len_clamped;
`ifdef TFTP_CSUM_EN
  logic [15:0] csum;
`endif

  modport master (
    input  cmd_valid, cmd_block, cmd_length, mem_dr, mem_dv, mem_data, tx_ready,
    output cmd_ready, mem_read_request, tx_data, tx_valid, tx_sof, tx_eof, tx_len, len_clamped
`ifdef TFTP_CSUM_EN
    , output csum
`endif
  );

  modport slave (
    output cmd_valid, cmd_block, cmd_length, mem_dr, mem_dv, mem_data, tx_ready,
    input  cmd_ready, mem_read_request, tx_data, tx_valid, tx_sof, tx_eof, tx_len, len_clamped
`ifdef TFTP_CSUM_EN
    , input csum
`endif
  );
endinterface

// File: rtl/tftp_data_packer.sv
// Builds one TFTP DATA packet (opcode, block, payload) per command, buffering the payload in a FIFO.
// Define TFTP_CSUM_EN to add a running one's-complement checksum output.
module tftp_data_packer #(
  parameter int unsigned MAX_PAYLOAD = 512,
  parameter int unsigned PTR_BITS    = 9
) (
  input logic               clk,
  input logic               reset,
  tftp_data_packer_if.master bus
);
  localparam int unsigned      LEN_W   = 16;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_HDR, S_PAY, S_DONE} state_t;

  state_t              state;
  logic [LEN_W-1:0]    blk_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    fill_cnt;
  logic [1:0]          hdr_idx;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [7:0]          fifo_mem [MAX_PAYLOAD];

  logic             accept_c;
  logic             xfer_c;
  logic             fifo_wr_c;
  logic [LEN_W-1:0] cmd_len_c;

  assign accept_c  = bus.cmd_valid && bus.cmd_ready;
  assign xfer_c    = bus.tx_valid && bus.tx_ready;
  assign fifo_wr_c = (state == S_FILL) && bus.mem_dv && (fill_cnt < len_r);
  assign cmd_len_c = (bus.cmd_length > MAX_LEN) ? MAX_LEN : bus.cmd_length;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [LEN_W-1:0] blk);
    case (idx)
      2'd0:    return 8'h00;
      2'd1:    return 8'h03;
      2'd2:    return blk[15:8];
      default: return blk[7:0];
    endcase
  endfunction

  // Payload storage; no reset needed, pointers define validity.
  always_ff @(posedge clk) begin
    if (fifo_wr_c) fifo_mem[wr_ptr] <= bus.mem_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      bus.cmd_ready        <= 1'b0;
      bus.mem_read_request <= 1'b0;
      bus.tx_data          <= 8'h00;
      bus.tx_valid         <= 1'b0;
      bus.tx_sof           <= 1'b0;
      bus.tx_eof           <= 1'b0;
      bus.tx_len           <= '0;
      bus.len_clamped      <= 1'b0;
      blk_r                <= '0;
      len_r                <= '0;
      fill_cnt             <= '0;
      hdr_idx              <= '0;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
    end else begin
      bus.mem_read_request <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (accept_c) begin
            bus.cmd_ready   <= 1'b0;
            blk_r           <= bus.cmd_block;
            len_r           <= cmd_len_c;
            bus.len_clamped <= (bus.cmd_length > MAX_LEN);
            bus.tx_len      <= cmd_len_c + HDR_LEN;
            state           <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_dr) begin
            bus.mem_read_request <= 1'b1;
            fill_cnt             <= '0;
            state                <= (len_r == '0) ? S_HDR : S_FILL;
          end
        end
        S_FILL: begin
          if (fifo_wr_c) begin
            wr_ptr   <= wr_ptr + PTR_BITS'(1);
            fill_cnt <= fill_cnt + LEN_W'(1);
            if (fill_cnt + LEN_W'(1) == len_r) state <= S_HDR;
          end
        end
        S_HDR: begin
          // First HDR cycle loads byte 0; tx_valid then stays up into PAY.
          if (!bus.tx_valid) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= 8'h00;
            bus.tx_sof   <= 1'b1;
            bus.tx_eof   <= 1'b0;
            hdr_idx      <= 2'd0;
          end else if (xfer_c) begin
            bus.tx_sof <= 1'b0;
            if (hdr_idx == 2'd3) begin
              if (len_r == '0) begin
                bus.tx_valid <= 1'b0;
                bus.tx_eof   <= 1'b0;
                bus.tx_data  <= 8'h00;
                state        <= S_DONE;
              end else begin
                bus.tx_data <= fifo_mem[rd_ptr];
                rd_ptr      <= rd_ptr + PTR_BITS'(1);
                bus.tx_eof  <= (len_r == LEN_W'(1));
                state       <= S_PAY;
              end
            end else begin
              hdr_idx     <= hdr_idx + 2'd1;
              bus.tx_data <= hdr_byte(hdr_idx + 2'd1, blk_r);
              bus.tx_eof  <= (hdr_idx == 2'd2) && (len_r == '0);
            end
          end
        end
        S_PAY: begin
          if (xfer_c) begin
            if (bus.tx_eof) begin
              bus.tx_valid <= 1'b0;
              bus.tx_eof   <= 1'b0;
              bus.tx_data  <= 8'h00;
              state        <= S_DONE;
            end else begin
              bus.tx_data <= fifo_mem[rd_ptr];
              rd_ptr      <= rd_ptr + PTR_BITS'(1);
              bus.tx_eof  <= (LEN_W'(rd_ptr) == len_r - LEN_W'(1));
            end
          end
        end
        S_DONE: begin
          wr_ptr        <= '0;
          rd_ptr        <= '0;
          fill_cnt      <= '0;
          bus.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TFTP_CSUM_EN
  logic        odd_r;
  logic [15:0] csum_add_c;
  logic [16:0] csum_sum_c;

  // Even-position bytes are word high bytes; a lone trailing byte gets a zero low byte for free.
  always_comb begin
    csum_add_c = odd_r ? {8'h00, bus.tx_data} : {bus.tx_data, 8'h00};
    csum_sum_c = {1'b0, bus.csum} + {1'b0, csum_add_c};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.csum <= '0;
      odd_r    <= 1'b0;
    end else if (accept_c) begin
      bus.csum <= '0;
      odd_r    <= 1'b0;
    end else if (xfer_c) begin
      bus.csum <= csum_sum_c[15:0] + 16'(csum_sum_c[16]);
      odd_r    <= ~odd_r;
    end
  end
`endif
endmodule
